serializador_param: RTL and testbench
=====================================

// Module: serializador_param
//
// PURPOSE
//  Parametrised parallel-to-serial converter, next generation of the 8-bit serializer.
//  Takes WIDTH-bit words through a valid/ready handshake and shifts them out one bit per clk on a single (rising) edge.
//  Words stream back-to-back with no gap cycle; IDLE_BIT fills the line when no word is pending.
//  A per-word data/control flag (DK) rides alongside each word.
//  Sits between the word-level TX logic and the line driver of the serdes path.
//
// PARAMETERS
//  WIDTH     8  bits per word; legal range 2..32
//  MSB_FIRST 1  1: data[WIDTH-1] goes out first; 0: data[0] goes out first
//  IDLE_BIT  0  value driven on out while no word is being sent
//
// PORTS
//  clk    in   1      clock; all state updates on posedge
//  reset  in   1      synchronous, active-high reset
//  enb    in   1      1 = data/dk_in hold a valid word (valid)
//  data   in   WIDTH  parallel word
//  dk_in  in   1      word type: 1 = data word, 0 = control word
//  ready  out  1      block accepts a word this cycle (combinational)
//  out    out  1      serial bit (registered)
//  DK     out  1      dk_in of the word currently on out; held for all WIDTH bits
//  frame  out  1      high during the bit period of the first bit of each word
//  busy   out  1      high while a word is being shifted out
//
// BEHAVIOUR
//  - Reset (reset=1 at posedge): state=IDLE, count=0, shift reg=0,
//    out=IDLE_BIT, DK=0, frame=0, busy=0. ready=0 while reset is high.
//  - Handshake: a word is accepted at the posedge where enb=1 and ready=1.
//    When enb=1 and ready=0, the input is ignored (not queued). The source holds the word until accepted.
//  - ready = !reset && (state==IDLE || count==WIDTH-1).
//  - FSM with two states:
//    IDLE:  out=IDLE_BIT, busy=0. On accept: load shift reg, latch DK, count=0, go to SHIFT.
//    SHIFT: busy=1. count increments each clk.
//           At count==WIDTH-1 with accept: reload the shift reg, count=0, stay in SHIFT (seamless stream).
//           At count==WIDTH-1 without accept: go to IDLE.
//  - Latency: a word accepted at edge N drives its first bit on out from edge N until edge N+1.
//    Its last bit is driven from edge N+WIDTH-1. Exactly WIDTH bit periods per word.
//  - Bit order:
//    MSB_FIRST=1: bit k of the stream (k=0..WIDTH-1) = data[WIDTH-1-k].
//    MSB_FIRST=0: bit k of the stream = data[k].
//  - frame=1 only in the bit period where count==0 in SHIFT.
//  - DK updates only on accept; it holds through every bit of the word.
//  - count width = $clog2(WIDTH). count never exceeds WIDTH-1 and wraps to 0 only on reload.
//  - When the stream returns to IDLE, DK keeps its last value and out returns to IDLE_BIT.
//  - Reset during SHIFT aborts the word immediately. No partial bits are driven after the reset edge.
//  - Changes on data/dk_in outside the accept edge have no effect on out.
//
// TESTING  (WIDTH=8 unless noted)
//  1. Reset, then enb=1 with data=8'hA5, dk_in=1 for one cycle.
//     -> out = 1,0,1,0,0,1,0,1 over 8 cycles; frame high on the 1st bit only; DK=1 throughout;
//        busy=1 for 8 cycles; then out=IDLE_BIT and busy=0.
//  2. Back-to-back 8'hA5 then 8'h3C (enb held, 2nd word accepted at count==7).
//     -> 16 contiguous bits 10100101 00111100 with no idle gap; frame pulses at bits 0 and 8.
//  3. MSB_FIRST=0, data=8'h01.
//     -> out = 1,0,0,0,0,0,0,0. Then WIDTH=12 with 12'hF0F, MSB first -> 111100001111.
//  4. Reset asserted at the 4th bit of 8'hFF.
//     -> the next cycle gives out=IDLE_BIT, busy=0, DK=0, ready=0 while reset is high.
//        After reset releases, a new word 8'h81 serialises cleanly.
//  5. A 2nd word is offered (enb=1, data=8'h00) at count==3 of 8'hFF.
//     -> ready=0, the word is not accepted, and the stream stays 11111111.
//        The word is accepted at count==7 and follows without a gap.
//  6. dk_in toggles 0/1 across 3 streamed words.
//     -> DK changes only at each frame bit and matches each word's dk_in.

Source files
------------

// File: rtl/serializador_param.sv
// -----------------------------------------------------------------------------
// serializador_param
//   Parametrised parallel-to-serial converter. WIDTH-bit words are accepted
//   through a valid/ready handshake and shifted out one bit per clock on
//   "out". A new word is accepted during the last bit period of the current
//   word, so words stream back-to-back with no gap. IDLE_BIT fills the line
//   whenever no word is being sent. A data/control flag (DK) travels with
//   each word and is held for all of its bits.
//
// Ports
//   clk    in   1      clock, all state updates on the rising edge
//   reset  in   1      synchronous, active-high reset
//   enb    in   1      data/dk_in hold a valid word
//   data   in   WIDTH  parallel word
//   dk_in  in   1      word type: 1 = data word, 0 = control word
//   ready  out  1      a word is accepted this cycle if enb=1 (combinational)
//   out    out  1      serial bit (registered)
//   DK     out  1      dk_in of the word currently on out
//   frame  out  1      high during the first bit period of each word
//   busy   out  1      high while a word is being shifted out
// -----------------------------------------------------------------------------
module serializador_param #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enb,
  input  logic [WIDTH-1:0] data,
  input  logic             dk_in,
  output logic             ready,
  output logic             out,
  output logic             DK,
  output logic             frame,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             out_q, out_d;
  logic             dk_q, dk_d;
  logic [WIDTH-1:0] word_ord;
  logic             accept;

  // Re-order the incoming word so the bit that must leave first always sits
  // in the top position; the shifter then only ever shifts left.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
      if (MSB_FIRST) begin : g_msb
        assign word_ord[gi] = data[gi];
      end else begin : g_lsb
        assign word_ord[gi] = data[WIDTH-1-gi];
      end
    end
  endgenerate

  assign accept = enb && ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        // A reload on the last bit keeps us in SHIFT for a seamless stream.
        if ((count_q == LAST) && !accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy  = (state_q == SHIFT);
    frame = (state_q == SHIFT) && (count_q == '0);
    // count is held at 0 in IDLE, so the last-bit test only fires in SHIFT.
    ready = !reset && ((state_q == IDLE) || (count_q == LAST));
  end

  // ---------------------------------------------------------------------------
  // Datapath: bit counter, shifter, serial output and DK flag
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    shift_d = shift_q;
    out_d   = out_q;
    dk_d    = dk_q;
    if (accept) begin
      // The first bit is driven straight from the input word at the accept
      // edge; the shifter keeps only the bits still to come.
      out_d   = word_ord[WIDTH-1];
      shift_d = {word_ord[WIDTH-2:0], 1'b0};
      count_d = '0;
      dk_d    = dk_in;
    end else if (state_q == SHIFT) begin
      if (count_q == LAST) begin
        out_d   = IDLE_BIT;
        count_d = '0;
        shift_d = '0;
      end else begin
        out_d   = shift_q[WIDTH-1];
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      shift_q <= '0;
      out_q   <= IDLE_BIT;
      dk_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      dk_q    <= dk_d;
    end
  end

  assign out = out_q;
  assign DK  = dk_q;

endmodule

// File: tb/tb_serializador_param.sv
// -----------------------------------------------------------------------------
// tb_serializador_param
//   Three instances driven from the same stimulus:
//     0: WIDTH=8,  MSB first
//     1: WIDTH=8,  LSB first
//     2: WIDTH=12, MSB first
//   A word-level model (accepted word + bit position) predicts every output
//   each cycle; directed literals pin the serial streams of each scenario.
// -----------------------------------------------------------------------------
module tb_serializador_param;

  logic        clk;
  logic        reset;
  logic        enb;
  logic [11:0] data12;
  logic        dk_in;
  logic [2:0]  o_rd, o_out, o_dk, o_fr, o_bz;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  serializador_param #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_m (
    .clk(clk), .reset(reset), .enb(enb), .data(data12[7:0]), .dk_in(dk_in),
    .ready(o_rd[0]), .out(o_out[0]), .DK(o_dk[0]), .frame(o_fr[0]), .busy(o_bz[0]));

  serializador_param #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_l (
    .clk(clk), .reset(reset), .enb(enb), .data(data12[7:0]), .dk_in(dk_in),
    .ready(o_rd[1]), .out(o_out[1]), .DK(o_dk[1]), .frame(o_fr[1]), .busy(o_bz[1]));

  serializador_param #(.WIDTH(12), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_w (
    .clk(clk), .reset(reset), .enb(enb), .data(data12), .dk_in(dk_in),
    .ready(o_rd[2]), .out(o_out[2]), .DK(o_dk[2]), .frame(o_fr[2]), .busy(o_bz[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wof(input int i);
    return (i == 2) ? 12 : 8;
  endfunction

  function automatic bit msbof(input int i);
    return (i != 1);
  endfunction

  // ---------------------------------------------------------------------------
  // Word-level model: which word is on the line and which bit of it.
  // ---------------------------------------------------------------------------
  bit          m_act[3];
  int          m_k[3];
  logic [31:0] m_wd[3];
  bit          m_dk[3];
  bit          m_rdy;
  bit          model_ok = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      m_rdy = !m_act[i] || (m_k[i] == wof(i) - 1);
      if (reset) begin
        m_act[i] = 1'b0;
        m_k[i]   = 0;
        m_dk[i]  = 1'b0;
        model_ok = 1'b1;
      end else begin
        if (m_act[i]) begin
          m_k[i] = m_k[i] + 1;
          if (m_k[i] == wof(i)) m_act[i] = 1'b0;
        end
        if (enb && m_rdy) begin
          m_act[i] = 1'b1;
          m_k[i]   = 0;
          m_wd[i]  = (i == 2) ? {20'd0, data12} : {24'd0, data12[7:0]};
          m_dk[i]  = dk_in;
        end
      end
    end
  end

  task automatic cmp1(input string nm, input int i, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL cyc=%0d dut%0d %s got=%b want=%b", cyc, i, nm, got, want);
    end
  endtask

  task automatic compare_all();
    logic e_out;
    if (!model_ok) return;
    for (int i = 0; i < 3; i++) begin
      if (!m_act[i]) e_out = 1'b0;
      else if (msbof(i)) e_out = m_wd[i][wof(i) - 1 - m_k[i]];
      else e_out = m_wd[i][m_k[i]];
      cmp1("out",   i, o_out[i], e_out);
      cmp1("busy",  i, o_bz[i],  m_act[i]);
      cmp1("frame", i, o_fr[i],  m_act[i] && (m_k[i] == 0));
      cmp1("DK",    i, o_dk[i],  m_dk[i]);
      cmp1("ready", i, o_rd[i],  !reset && (!m_act[i] || (m_k[i] == wof(i) - 1)));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stream capture for the directed literal checks
  // ---------------------------------------------------------------------------
  logic [31:0] cap[3];
  int          nb[3];
  int          frc[3];
  int          dkbad[3];
  logic [7:0]  dkf[3];
  logic        prev_dk[3];

  task automatic clear_cap();
    for (int i = 0; i < 3; i++) begin
      cap[i] = '0; nb[i] = 0; frc[i] = 0; dkbad[i] = 0; dkf[i] = '0;
    end
  endtask

  task automatic capture();
    for (int i = 0; i < 3; i++) begin
      if (o_bz[i] === 1'b1) begin
        cap[i] = {cap[i][30:0], o_out[i]};
        nb[i]++;
      end
      if (o_fr[i] === 1'b1) begin
        frc[i]++;
        dkf[i] = {dkf[i][6:0], o_dk[i]};
      end
      if (!reset && (o_dk[i] !== prev_dk[i]) && (o_fr[i] !== 1'b1)) dkbad[i]++;
      prev_dk[i] = o_dk[i];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    compare_all();
    capture();
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Present a word and hold it until the 8-bit MSB-first instance takes it.
  // Returns in the first bit period of that word with enb still high.
  task automatic send(input logic [11:0] w, input logic d);
    int n;
    data12 = w;
    dk_in  = d;
    enb    = 1'b1;
    n = 0;
    while ((o_rd[0] !== 1'b1) && (n < 100)) begin
      tick();
      n++;
    end
    if (n >= 100) check("send_timeout", 32'd1, 32'd0);
    tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((o_bz !== 3'b000) && (n < 200)) begin
      tick();
      n++;
    end
    if (n >= 200) check("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    enb    = 1'b0;
    data12 = '0;
    dk_in  = 1'b0;
    for (int i = 0; i < 3; i++) prev_dk[i] = 1'b0;
    clear_cap();
    tick(); tick(); tick();

    // Reset state
    check("rst_out",   {31'd0, o_out[0]}, 32'd0);
    check("rst_busy",  {31'd0, o_bz[0]},  32'd0);
    check("rst_frame", {31'd0, o_fr[0]},  32'd0);
    check("rst_dk",    {31'd0, o_dk[0]},  32'd0);
    check("rst_ready", {29'd0, o_rd},     32'd0);
    reset = 1'b0;
    tick();
    check("idle_ready", {29'd0, o_rd}, 32'd7);

    // 1: single word A5, data word
    clear_cap();
    send(12'h0A5, 1'b1);
    enb = 1'b0;
    wait_idle();
    check("t1_stream",  cap[0], 32'h0000_00A5);
    check("t1_lsb",     cap[1], 32'h0000_00A5);
    check("t1_wide",    cap[2], 32'h0000_00A5);
    check("t1_bits",    nb[0],  32'd8);
    check("t1_frames",  frc[0], 32'd1);
    check("t1_dk_hold", {31'd0, o_dk[0]},  32'd1);
    check("t1_idle",    {31'd0, o_out[0]}, 32'd0);

    // 2: back-to-back A5 then 3C
    clear_cap();
    send(12'h0A5, 1'b1);
    send(12'h03C, 1'b0);
    enb = 1'b0;
    wait_idle();
    check("t2_stream", cap[0], 32'h0000_A53C);
    check("t2_bits",   nb[0],  32'd16);
    check("t2_frames", frc[0], 32'd2);

    // 3: LSB-first 01, then 12-bit F0F MSB-first
    clear_cap();
    send(12'h001, 1'b1);
    enb = 1'b0;
    wait_idle();
    check("t3_lsb",     cap[1], 32'h0000_0080);
    check("t3_msb",     cap[0], 32'h0000_0001);
    clear_cap();
    send(12'hF0F, 1'b0);
    enb = 1'b0;
    wait_idle();
    check("t3_wide",      cap[2], 32'h0000_0F0F);
    check("t3_wide_bits", nb[2],  32'd12);

    // 4: reset during the 4th bit of FF
    clear_cap();
    send(12'h0FF, 1'b1);
    enb = 1'b0;
    tick(); tick(); tick();
    check("t4_bits_before", nb[0], 32'd4);
    reset = 1'b1;
    tick();
    check("t4_out",   {31'd0, o_out[0]}, 32'd0);
    check("t4_busy",  {29'd0, o_bz},     32'd0);
    check("t4_dk",    {31'd0, o_dk[0]},  32'd0);
    check("t4_ready", {29'd0, o_rd},     32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("t4_no_partial", nb[0], 32'd4);
    clear_cap();
    send(12'h081, 1'b0);
    enb = 1'b0;
    wait_idle();
    check("t4_after", cap[0], 32'h0000_0081);
    check("t4_after_bits", nb[0], 32'd8);

    // 5: second word offered mid-word is held off until the last bit
    clear_cap();
    send(12'h0FF, 1'b1);
    data12 = 12'h000;
    dk_in  = 1'b0;
    enb    = 1'b1;
    tick(); tick(); tick();
    check("t5_ready_cnt3", {31'd0, o_rd[0]}, 32'd0);
    send(12'h000, 1'b0);
    enb = 1'b0;
    wait_idle();
    check("t5_stream", cap[0], 32'h0000_FF00);
    check("t5_bits",   nb[0],  32'd16);
    check("t5_frames", frc[0], 32'd2);

    // 6: DK follows each streamed word
    clear_cap();
    send(12'h012, 1'b0);
    send(12'h034, 1'b1);
    send(12'h056, 1'b0);
    enb = 1'b0;
    wait_idle();
    check("t6_stream", cap[0], 32'h0012_3456);
    check("t6_frames", frc[0], 32'd3);
    check("t6_dk_seq", {29'd0, dkf[0][2:0]}, 32'd2);
    check("t6_dk_only_at_frame", dkbad[0], 32'd0);

    for (int i = 0; i < 5; i++) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
